uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter through a start/done handshake
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst_l,
    input  logic          wr_enH,
    input  logic [7:0]    wr_dataH,
    input  logic          clr_ovfH,
    output logic          fullH,
    output logic          emptyH,
    output logic [AW:0]   countH,
    output logic          overflowH,
    output logic          tx_busyH,
    output logic          xmitH,
    output logic [7:0]    xmit_dataH,
    input  logic          xmit_doneH
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t        state_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          ovf_q;
    logic          ovf_d;
    logic          xmit_q;
    logic          busy_q;
    logic [7:0]    xdata_q;
    logic          accept;
    logic          launch;

    // Both decisions use the registered flags, so a write while full is dropped even if a pop happens this cycle.
    assign accept = wr_enH & ~full_q;
    assign launch = (state_q == S_IDLE) & ~empty_q & xmit_doneH;

    always_comb begin
        count_d = count_q;
        if (accept && !launch) begin
            count_d = count_q + CNT_ONE;
        end else if (!accept && launch) begin
            count_d = count_q - CNT_ONE;
        end
        ovf_d = (wr_enH & full_q) | (ovf_q & ~clr_ovfH);
    end

    always_ff @(posedge sys_clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= wr_dataH;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            xmit_q   <= 1'b0;
            busy_q   <= 1'b0;
            xdata_q  <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        state_q  <= S_LAUNCH;
                        rd_ptr_q <= rd_ptr_q + PTR_ONE;
                        xdata_q  <= mem_q[rd_ptr_q];
                        xmit_q   <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    if (!xmit_doneH) begin
                        state_q <= S_WAIT_DONE;
                        xmit_q  <= 1'b0;
                    end
                end
                S_WAIT_DONE: begin
                    if (xmit_doneH) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    xmit_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fullH      = full_q;
    assign emptyH     = empty_q;
    assign countH     = count_q;
    assign overflowH  = ovf_q;
    assign tx_busyH   = busy_q;
    assign xmitH      = xmit_q;
    assign xmit_dataH = xdata_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with serial transmitter/receiver models
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int BITC  = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst_l;
    logic          wr_enH;
    logic [7:0]    wr_dataH;
    logic          clr_ovfH;
    logic          fullH;
    logic          emptyH;
    logic [AW:0]   countH;
    logic          overflowH;
    logic          tx_busyH;
    logic          xmitH;
    logic [7:0]    xmit_dataH;
    logic          xmit_doneH;
    logic          txd;

    int total = 0;
    int bad   = 0;
    int rx_cnt = 0;
    bit chk_en = 1'b0;

    logic [7:0] mq[$];
    logic [7:0] sb[$];
    int         m_ph;
    bit         m_ovf;
    logic [7:0] m_data;
    bit         m_full;
    bit         m_lau;
    bit         m_acc;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_l  (sys_rst_l),
        .wr_enH     (wr_enH),
        .wr_dataH   (wr_dataH),
        .clr_ovfH   (clr_ovfH),
        .fullH      (fullH),
        .emptyH     (emptyH),
        .countH     (countH),
        .overflowH  (overflowH),
        .tx_busyH   (tx_busyH),
        .xmitH      (xmitH),
        .xmit_dataH (xmit_dataH),
        .xmit_doneH (xmit_doneH)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus a three-phase view of the handshake (idle / start held / sending).
    always @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            mq.delete();
            sb.delete();
            m_ph   = 0;
            m_ovf  = 1'b0;
            m_data = 8'h00;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_lau  = (m_ph == 0) && (mq.size() != 0) && (xmit_doneH == 1'b1);
            m_acc  = wr_enH && !m_full;
            if (m_lau) m_data = mq.pop_front();
            if (m_acc) begin
                mq.push_back(wr_dataH);
                sb.push_back(wr_dataH);
            end
            if (wr_enH && m_full) m_ovf = 1'b1;
            else if (clr_ovfH) m_ovf = 1'b0;
            case (m_ph)
                0: if (m_lau) m_ph = 1;
                1: if (!xmit_doneH) m_ph = 2;
                default: if (xmit_doneH) m_ph = 0;
            endcase
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en && sys_rst_l) begin
            chk("count", int'(countH), mq.size());
            chk("full", int'(fullH), int'(mq.size() == DEPTH));
            chk("empty", int'(emptyH), int'(mq.size() == 0));
            chk("overflow", int'(overflowH), int'(m_ovf));
            chk("xmit", int'(xmitH), int'(m_ph == 1));
            chk("busy", int'(tx_busyH), int'(m_ph != 0));
            chk("xmit_data", int'(xmit_dataH), int'(m_data));
        end
    end

    // Serial receiver: rebuilds each byte from txd and checks it against the scoreboard.
    initial begin
        logic [7:0] rb;
        forever begin
            @(negedge txd);
            repeat (BITC / 2) @(posedge sys_clk);
            for (int k = 0; k < 8; k++) begin
                repeat (BITC) @(posedge sys_clk);
                rb[k] = txd;
            end
            repeat (BITC) @(posedge sys_clk);
            chk("rx_stop", int'(txd), 1);
            if (sb.size() == 0) begin
                chk("rx_unexpected", int'(rb), -1);
            end else begin
                chk("rx_byte", int'(rb), int'(sb.pop_front()));
            end
            rx_cnt++;
        end
    end

    task automatic wr(input logic [7:0] b);
        wr_enH   = 1'b1;
        wr_dataH = b;
        @(negedge sys_clk);
        wr_enH   = 1'b0;
    endtask

    task automatic drain(input int n, input bit check_seq, input int start);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            while (!xmitH && g < 20) begin
                @(negedge sys_clk);
                g++;
            end
            chk("launch_seen", int'(xmitH), 1);
            if (check_seq) chk("drain_order", int'(xmit_dataH), start + i);
            xmit_doneH = 1'b0;
            @(negedge sys_clk);
            xmit_doneH = 1'b1;
            @(negedge sys_clk);
        end
    endtask

    task automatic tx_engine(input int nbytes);
        int cnt = 0;
        int guard = 0;
        logic [7:0] b;
        while (cnt < nbytes && guard < 20000) begin
            @(negedge sys_clk);
            guard++;
            if (xmitH) begin
                b = xmit_dataH;
                xmit_doneH = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    txd = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                    repeat (BITC) @(negedge sys_clk);
                end
                xmit_doneH = 1'b1;
                cnt++;
            end
        end
        chk("tx_engine_count", cnt, nbytes);
    endtask

    task automatic rand_writer(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            int g = 0;
            while (fullH && g < 2000) begin
                @(negedge sys_clk);
                g++;
            end
            wr(8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_l  = 1'b0;
        wr_enH     = 1'b0;
        wr_dataH   = 8'h00;
        clr_ovfH   = 1'b0;
        xmit_doneH = 1'b1;
        txd        = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_count", int'(countH), 0);
        chk("rst_empty", int'(emptyH), 1);
        chk("rst_full", int'(fullH), 0);
        chk("rst_xmit", int'(xmitH), 0);
        chk("rst_busy", int'(tx_busyH), 0);
        chk("rst_data", int'(xmit_dataH), 0);
        chk("rst_ovf", int'(overflowH), 0);
        sys_rst_l = 1'b1;
        chk_en    = 1'b1;
        @(negedge sys_clk);

        // single byte, then held handshake with a second byte queued
        wr(8'hA5);
        chk("single_not_empty", int'(emptyH), 0);
        @(negedge sys_clk);
        chk("single_xmit", int'(xmitH), 1);
        chk("single_data", int'(xmit_dataH), 8'hA5);
        chk("single_empty_after_pop", int'(emptyH), 1);
        wr(8'h3C);
        chk("hold_xmit1", int'(xmitH), 1);
        @(negedge sys_clk);
        chk("hold_xmit2", int'(xmitH), 1);
        @(negedge sys_clk);
        chk("hold_xmit3", int'(xmitH), 1);
        xmit_doneH = 1'b0;
        @(negedge sys_clk);
        chk("wait_xmit_low", int'(xmitH), 0);
        chk("wait_busy", int'(tx_busyH), 1);
        @(negedge sys_clk);
        xmit_doneH = 1'b1;
        @(negedge sys_clk);
        chk("done_busy_low", int'(tx_busyH), 0);
        chk("gap_no_xmit", int'(xmitH), 0);
        @(negedge sys_clk);
        chk("next_launch", int'(xmitH), 1);
        chk("next_data", int'(xmit_dataH), 8'h3C);
        drain(1, 1'b0, 0);

        // fill past full with the transmitter busy
        xmit_doneH = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            wr_enH   = 1'b1;
            wr_dataH = 8'(i);
            @(negedge sys_clk);
        end
        wr_enH = 1'b0;
        chk("fill_full", int'(fullH), 1);
        chk("fill_count", int'(countH), DEPTH);
        chk("fill_ovf", int'(overflowH), 1);
        clr_ovfH = 1'b1;
        @(negedge sys_clk);
        clr_ovfH = 1'b0;
        chk("ovf_cleared", int'(overflowH), 0);
        xmit_doneH = 1'b1;
        drain(DEPTH, 1'b1, 0);
        repeat (2) @(negedge sys_clk);
        chk("fill_drained_empty", int'(emptyH), 1);
        chk("dropped_not_sent", int'(xmitH), 0);

        // write in the same cycle as a launch
        xmit_doneH = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'h20 + 8'(i));
        chk("sim_count_before", int'(countH), 5);
        xmit_doneH = 1'b1;
        wr(8'h55);
        chk("sim_count_after", int'(countH), 5);
        chk("sim_launch", int'(xmitH), 1);
        chk("sim_data", int'(xmit_dataH), 8'h20);
        drain(6, 1'b0, 0);
        chk("sim_drained", int'(emptyH), 1);

        // reset while waiting for done with three bytes queued
        xmit_doneH = 1'b0;
        for (int i = 0; i < 4; i++) wr(8'h30 + 8'(i));
        xmit_doneH = 1'b1;
        @(negedge sys_clk);
        xmit_doneH = 1'b0;
        @(negedge sys_clk);
        chk("midrst_busy", int'(tx_busyH), 1);
        chk("midrst_count", int'(countH), 3);
        #2 sys_rst_l = 1'b0;
        #1;
        chk("arst_count", int'(countH), 0);
        chk("arst_empty", int'(emptyH), 1);
        chk("arst_busy", int'(tx_busyH), 0);
        chk("arst_xmit", int'(xmitH), 0);
        chk("arst_data", int'(xmit_dataH), 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_l  = 1'b1;
        xmit_doneH = 1'b1;
        wr(8'h77);
        @(negedge sys_clk);
        chk("post_rst_launch", int'(xmitH), 1);
        chk("post_rst_data", int'(xmit_dataH), 8'h77);
        drain(1, 1'b0, 0);
        repeat (3) @(negedge sys_clk);
        chk("post_rst_only_one", int'(xmitH), 0);
        chk("post_rst_empty", int'(emptyH), 1);

        // randomized stream through a serial transmitter model
        sys_rst_l = 1'b0;
        @(negedge sys_clk);
        sys_rst_l = 1'b1;
        fork
            rand_writer(40);
            tx_engine(40);
        join
        repeat (20) @(negedge sys_clk);
        chk("rx_count", rx_cnt, 40);
        chk("sb_empty", sb.size(), 0);
        chk("stream_empty", int'(emptyH), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
